// File: rtl/median_pkg.sv
// Shared sizing helpers for the sliding-window median filter.
// Latency: n/a (elaboration-time constants and checks only).
// Backpressure: n/a.
package median_pkg;

    // Fill counter width: must represent 0..win inclusive.
    function automatic int cnt_w(input int win);
        return $clog2(win + 1);
    endfunction

    // Slot index of the median in an ascending window of odd depth.
    function automatic int mid_idx(input int win);
        return win / 2;
    endfunction

    // Window depth must be odd so the median is a single slot.
    function automatic bit win_ok(input int win);
        return (win % 2 == 1) && (win >= 3) && (win <= 15);
    endfunction

    // Supported unsigned sample widths.
    function automatic bit width_ok(input int width);
        return (width >= 2) && (width <= 16);
    endfunction

endpackage

// File: rtl/median_sort_cell.sv
// One slot of the sorted window: picks its next value from stay/shift/new.
// Latency: purely combinational, registered by the parent.
// Backpressure: none; evaluated every cycle.
module median_sort_cell #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] own_val,
    input  logic [WIDTH-1:0] left_val,
    input  logic [WIDTH-1:0] right_val,
    input  logic [WIDTH-1:0] new_val,
    input  logic             before_ins,
    input  logic             ins_here,
    input  logic             ev_at_below,
    input  logic             ev_left,
    output logic [WIDTH-1:0] next_val
);

    // Slots below the insert point close the eviction gap from the right;
    // slots above it make room for the new sample by taking the left value,
    // unless the gap left by the evicted slot already absorbed that shift.
    always_comb begin
        next_val = own_val;
        if (before_ins) begin
            next_val = ev_at_below ? right_val : own_val;
        end else if (ins_here) begin
            next_val = new_val;
        end else begin
            next_val = ev_left ? own_val : left_val;
        end
    end

endmodule

// File: rtl/median_window_filter.sv
// Streaming median/min/max over the last WIN unsigned samples.
// Latency: 1 cycle from accepted sample to registered outputs.
// Backpressure: none; a sample is taken every cycle in_valid is high.
module median_window_filter
    import median_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WIN   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_median,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max
);

    localparam int CNT_W = cnt_w(WIN);
    localparam int MID   = mid_idx(WIN);

    if (!win_ok(WIN)) begin : g_bad_win
        $error("median_window_filter: WIN must be odd and within 3..15");
    end
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("median_window_filter: WIDTH must be within 2..16");
    end

    logic [WIN-1:0][WIDTH-1:0] h_q, h_d;
    logic [WIN-1:0][WIDTH-1:0] s_q, s_d;
    logic [WIN-1:0][WIDTH-1:0] s_next;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [WIDTH-1:0]          out_median_q, out_median_d;
    logic [WIDTH-1:0]          out_min_q, out_min_d;
    logic [WIDTH-1:0]          out_max_q, out_max_d;

    logic                      full;
    logic [WIDTH-1:0]          oldest;
    logic [WIN-1:0]            le;
    logic [WIN-1:0]            evb;
    logic [WIN-1:0]            rle;
    logic [WIN-1:0]            ins_here;

    // Compare every slot against the new sample and against the evicted one;
    // evb marks slots at or above the lowest slot holding the evicted value.
    always_comb begin
        logic run;
        full   = (cnt_q == CNT_W'(WIN));
        oldest = h_q[WIN-1];
        run    = 1'b0;
        le     = '0;
        evb    = '0;
        for (int i = 0; i < WIN; i++) begin
            le[i]  = (s_q[i] <= in_data);
            run    = run | (full & (s_q[i] == oldest));
            evb[i] = run;
        end
    end

    // Per slot: rle says the compacted (post-eviction) value here is <= the
    // new sample, so the sample lands above it; empty fill slots never are.
    for (genvar i = 0; i < WIN; i++) begin : g_slot
        logic [WIDTH-1:0] left_val;
        logic [WIDTH-1:0] right_val;
        logic             rle_full;
        logic             ev_left;

        if (i == 0) begin : g_first
            assign left_val    = s_q[i];
            assign ev_left     = 1'b0;
            assign ins_here[i] = ~rle[i];
        end else begin : g_inner
            assign left_val    = s_q[i-1];
            assign ev_left     = evb[i-1];
            assign ins_here[i] = ~rle[i] & rle[i-1];
        end

        if (i == WIN - 1) begin : g_last
            assign right_val = s_q[i];
            assign rle_full  = 1'b0;
        end else begin : g_body
            assign right_val = s_q[i+1];
            assign rle_full  = evb[i] ? le[i+1] : le[i];
        end

        assign rle[i] = full ? rle_full : ((CNT_W'(i) < cnt_q) & le[i]);

        median_sort_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .own_val    (s_q[i]),
            .left_val   (left_val),
            .right_val  (right_val),
            .new_val    (in_data),
            .before_ins (rle[i]),
            .ins_here   (ins_here[i]),
            .ev_at_below(evb[i]),
            .ev_left    (ev_left),
            .next_val   (s_next[i])
        );
    end

    // Next state: clear flushes the count (and beats a same-cycle sample);
    // an accept shifts history, commits the re-sorted window and, once the
    // window is full, loads the outputs from the updated sort.
    always_comb begin
        cnt_d        = cnt_q;
        h_d          = h_q;
        s_d          = s_q;
        out_valid_d  = 1'b0;
        out_median_d = out_median_q;
        out_min_d    = out_min_q;
        out_max_d    = out_max_q;
        if (clear) begin
            cnt_d = '0;
        end else if (in_valid) begin
            h_d = {h_q[WIN-2:0], in_data};
            s_d = s_next;
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (full || (cnt_q == CNT_W'(WIN - 1))) begin
                out_valid_d  = 1'b1;
                out_median_d = s_next[MID];
                out_min_d    = s_next[0];
                out_max_d    = s_next[WIN-1];
            end
        end
    end

    // State and output registers with asynchronous clear to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            h_q          <= '0;
            s_q          <= '0;
            out_valid_q  <= 1'b0;
            out_median_q <= '0;
            out_min_q    <= '0;
            out_max_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            h_q          <= h_d;
            s_q          <= s_d;
            out_valid_q  <= out_valid_d;
            out_median_q <= out_median_d;
            out_min_q    <= out_min_d;
            out_max_q    <= out_max_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_median = out_median_q;
    assign out_min    = out_min_q;
    assign out_max    = out_max_q;

endmodule

// File: tb/tb_median_window_filter.sv
// Directed bench for median_window_filter at WIN=3 and WIN=5, WIDTH=4.
// Both instances share one input stream; each scenario starts with a clear.
// Outputs are sampled 1 ns after the rising edge.
module tb_median_window_filter;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;

    logic       v3, v5;
    logic [3:0] med3, min3, max3;
    logic [3:0] med5, min5, max5;

    int n_tests;
    int n_fail;

    median_window_filter #(.WIDTH(4), .WIN(3)) u3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (v3),
        .out_median(med3),
        .out_min   (min3),
        .out_max   (max3)
    );

    median_window_filter #(.WIDTH(4), .WIN(5)) u5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (v5),
        .out_median(med5),
        .out_min   (min5),
        .out_max   (max5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Present one input for one clock, then return 1 ns after the edge.
    task automatic cyc(input logic v, input logic [3:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // Check one instance's outputs; values are only checked when valid is expected.
    task automatic expect_out(input string tag, input int sel, input int v,
                              input int med, input int mn, input int mx);
        int ov, om, on, ox;
        if (sel == 3) begin
            ov = int'(v3); om = int'(med3); on = int'(min3); ox = int'(max3);
        end else begin
            ov = int'(v5); om = int'(med5); on = int'(min5); ox = int'(max5);
        end
        check_eq({tag, ".vld"}, ov, v);
        if (v != 0) begin
            check_eq({tag, ".med"}, om, med);
            check_eq({tag, ".min"}, on, mn);
            check_eq({tag, ".max"}, ox, mx);
        end
    endtask

    initial begin
        int hist[$];
        int srt[5];
        int tmp;

        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        #12;
        check_eq("rst.vld3", int'(v3), 0);
        check_eq("rst.med3", int'(med3), 0);
        check_eq("rst.min3", int'(min3), 0);
        check_eq("rst.max3", int'(max3), 0);
        check_eq("rst.vld5", int'(v5), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill and slide, WIN=3: 5,1,9,3,3
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd5, 1'b0); expect_out("fs1", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd1, 1'b0); expect_out("fs2", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd9, 1'b0); expect_out("fs3", 3, 1, 5, 1, 9);
        cyc(1'b1, 4'd3, 1'b0); expect_out("fs4", 3, 1, 3, 1, 9);
        cyc(1'b1, 4'd3, 1'b0); expect_out("fs5", 3, 1, 3, 3, 9);

        // Duplicates, WIN=5: 7,7,7,2,7,2,2
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd7, 1'b0); expect_out("dup1", 5, 0, 0, 0, 0);
        cyc(1'b1, 4'd7, 1'b0); expect_out("dup2", 5, 0, 0, 0, 0);
        cyc(1'b1, 4'd7, 1'b0); expect_out("dup3", 5, 0, 0, 0, 0);
        cyc(1'b1, 4'd2, 1'b0); expect_out("dup4", 5, 0, 0, 0, 0);
        cyc(1'b1, 4'd7, 1'b0); expect_out("dup5", 5, 1, 7, 2, 7);
        cyc(1'b1, 4'd2, 1'b0); expect_out("dup6", 5, 1, 7, 2, 7);
        cyc(1'b1, 4'd2, 1'b0); expect_out("dup7", 5, 1, 2, 2, 7);

        // Gapped input, WIN=3: 4,_,8,_,_,6,_
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd4, 1'b0); expect_out("gap1", 3, 0, 0, 0, 0);
        cyc(1'b0, 4'd0, 1'b0); expect_out("gap2", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd8, 1'b0); expect_out("gap3", 3, 0, 0, 0, 0);
        cyc(1'b0, 4'd0, 1'b0); expect_out("gap4", 3, 0, 0, 0, 0);
        cyc(1'b0, 4'd0, 1'b0); expect_out("gap5", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd6, 1'b0); expect_out("gap6", 3, 1, 6, 4, 8);
        cyc(1'b0, 4'd0, 1'b0); expect_out("gap7", 3, 0, 0, 0, 0);
        check_eq("gap7.hold_med", int'(med3), 6);

        // Clear mid-stream, WIN=3: 1,2,3, clear+15, 9,9,9
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd1, 1'b0);
        cyc(1'b1, 4'd2, 1'b0);
        cyc(1'b1, 4'd3, 1'b0);  expect_out("clr0", 3, 1, 2, 1, 3);
        cyc(1'b1, 4'd15, 1'b1); expect_out("clr1", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd9, 1'b0);  expect_out("clr2", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd9, 1'b0);  expect_out("clr3", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd9, 1'b0);  expect_out("clr4", 3, 1, 9, 9, 9);

        // Asynchronous reset between edges
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd7, 1'b0);
        cyc(1'b1, 4'd8, 1'b0);
        cyc(1'b1, 4'd9, 1'b0);  expect_out("ar0", 3, 1, 8, 7, 9);
        cyc(1'b1, 4'd10, 1'b0); expect_out("ar1", 3, 1, 9, 8, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar.vld3", int'(v3), 0);
        check_eq("ar.med3", int'(med3), 0);
        check_eq("ar.min3", int'(min3), 0);
        check_eq("ar.max3", int'(max3), 0);
        check_eq("ar.med5", int'(med5), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 4'd2, 1'b0); expect_out("ar2", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd6, 1'b0); expect_out("ar3", 3, 0, 0, 0, 0);
        cyc(1'b1, 4'd4, 1'b0); expect_out("ar4", 3, 1, 4, 2, 6);

        // Extremes, WIN=5: alternating 0,15 against a sorting reference
        cyc(1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            logic [3:0] d;
            d = (k % 2 == 1) ? 4'd15 : 4'd0;
            cyc(1'b1, d, 1'b0);
            hist.push_back(int'(d));
            if (hist.size() > 5) void'(hist.pop_front());
            if (hist.size() == 5) begin
                for (int i = 0; i < 5; i++) srt[i] = hist[i];
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4 - i; j++) begin
                        if (srt[j] > srt[j+1]) begin
                            tmp      = srt[j];
                            srt[j]   = srt[j+1];
                            srt[j+1] = tmp;
                        end
                    end
                end
                expect_out("ext", 5, 1, srt[2], srt[0], srt[4]);
                check_eq("ext.min0", int'(min5), 0);
                check_eq("ext.max15", int'(max5), 15);
                check_eq("ext.alt", int'(med5), (k % 2 == 1) ? 15 : 0);
            end else begin
                expect_out("ext_fill", 5, 0, 0, 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
